// File: rtl/uart_rx_16os.sv
//------------------------------------------------------------------------------
// Module   : uart_rx_16os
// Brief    : UART receiver (8N1 default) timed by a 16x oversampling tick;
//            samples each bit at mid-bit and strobes every completed byte.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_16os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_16tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] C_TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] C_TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] C_BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [TW-1:0]          tick_cnt_q;
    logic [BW-1:0]          bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rx_done_q;
    logic                   frame_err_q;
    logic                   rx_meta_q;
    logic                   rx_s_q;

    // Two-flop synchronizer; reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_q    <= ST_START;
                        tick_cnt_q <= '0;
                    end
                end
                ST_START: begin
                    if (b_16tick) begin
                        if (tick_cnt_q == C_TICK_MID) begin
                            if (!rx_s_q) begin
                                state_q    <= ST_DATA;
                                tick_cnt_q <= '0;
                                bit_cnt_q  <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (b_16tick) begin
                        if (tick_cnt_q == C_TICK_LAST) begin
                            shift_q    <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                            tick_cnt_q <= '0;
                            if (bit_cnt_q == C_BIT_LAST) begin
                                state_q <= ST_STOP;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BW'(1);
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (b_16tick) begin
                        if (tick_cnt_q == C_TICK_LAST) begin
                            // Leaving at the stop-bit centre gives half a bit of slack for the next start edge.
                            if (rx_s_q) begin
                                rx_data_q <= shift_q;
                                rx_done_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                            tick_cnt_q <= '0;
                            state_q    <= ST_IDLE;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != ST_IDLE);

endmodule

`default_nettype wire
